game_round_ctrl: RTL and testbench
==================================

// Module: game_round_ctrl
// PURPOSE
//   Parametrised game-flow controller for the factorization game top level.
//   Turns level-sensitive KEY switches into synchronised edge events and runs the mode FSM (IDLE/READY/INPUT/RESULT/OVER).
//   Keeps the HP (lives) counter and a multi-digit BCD score, and drives the game-over LED.
//   Sits between the board inputs and the display/answer-check logic.
// PARAMETERS
//   NUM_KEYS       7   number of KEY switch inputs (>=2; KEY[0]=start/restart, KEY[1]=begin input)
//   HP_W           2   width of HP counter
//   HP_INIT        3   HP value after reset/restart (must be < 2**HP_W, >0)
//   DIGITS         3   number of BCD score digits
//   RESULT_CYCLES  16  cycles spent in RESULT before leaving it (>=1)
// PORTS
//   CLK          in   1           system clock, all state on rising edge
//   RST          in   1           asynchronous, active-low reset
//   KEY          in   NUM_KEYS    level switch inputs, 1 = on, asynchronous to CLK
//   JUDG         in   2           checker verdict: 00 none, 01 correct, 10 incorrect, 11 pass
//   JUDG_VLD     in   1           one-cycle qualifier for JUDG
//   WRONG        in   1           one-cycle external penalty pulse
//   MODE         out  3           FSM state: 0 IDLE, 1 READY, 2 INPUT, 3 RESULT, 4 OVER
//   HP_OUT       out  HP_W        remaining lives
//   COUNT_OUT    out  4*DIGITS    BCD score, digit 0 in [3:0]
//   KEY_EDGE     out  NUM_KEYS    one-cycle rising-edge pulses of synchronised KEY
//   ROUND_START  out  1           one-cycle pulse on every entry to INPUT
//   LEDR         out  1           1 while in OVER
// BEHAVIOUR
//   Reset (RST=0, async): MODE=IDLE, HP_OUT=HP_INIT, COUNT_OUT=0, KEY_EDGE=0, ROUND_START=0, LEDR=0; sync/prev regs=0.
//   - Key held through reset release produces exactly one edge.
//   KEY path: 2-flop synchroniser, then edge = sync & ~prev, registered.
//   - KEY_EDGE[i] rises 3 cycles after KEY[i] 0->1; no pulse on 1->0.
//   - Edges on several keys in one cycle are all reported.
//   FSM (transitions take effect on the edge after the qualifying pulse):
//   - IDLE   -> READY on KEY_EDGE[0].
//   - READY  -> INPUT on KEY_EDGE[1]; ROUND_START pulses in the first INPUT cycle.
//   - INPUT  -> RESULT on JUDG_VLD.
//   - RESULT -> after RESULT_CYCLES cycles: INPUT (with ROUND_START) if HP_OUT>0, else OVER.
//   - OVER   -> IDLE on KEY_EDGE[0]; HP_OUT reloads HP_INIT, COUNT_OUT clears in the same cycle.
//   - All other key edges are ignored by the FSM.
//   Verdict, applied on the JUDG_VLD cycle in INPUT only (ignored in any other state):
//   - 01: score +1, BCD ripple carry; at all-9s the score saturates (no wrap).
//   - 10: HP -1, saturating at 0.
//   - 11 / 00: no change.
//   WRONG:
//   - Accepted in INPUT and RESULT: HP -1, saturating at 0; ignored elsewhere.
//   - Same cycle as JUDG_VLD with 10: one decrement only (events merge).
//   - In RESULT, HP reaching 0 sends the exit to OVER.
//   Reset mid-operation: immediate return to reset values; any pending RESULT count is discarded.
//   All outputs are registered; no combinational path from inputs to outputs.
// TESTING
//   1 Reset, KEY=0000001 at t0 -> KEY_EDGE[0] pulses 3 cycles later, one cycle; MODE 0->1.
//   2 Then KEY=0000011 -> MODE=2, ROUND_START one pulse, HP_OUT=3, COUNT_OUT=000.
//   3 JUDG=01 with JUDG_VLD x12 rounds -> COUNT_OUT=0x012; each round holds MODE=3 for 16 cycles.
//   4 Preload score 999 (DIGITS=3), JUDG=01 -> stays 999.
//   5 JUDG=10 with JUDG_VLD and WRONG in the same cycle -> HP 3->2 (single decrement).
//   6 HP to 0 via JUDG=10 rounds -> MODE=4, LEDR=1; KEY[0] off/on -> MODE=0, HP=3, score=0.
//   7 RST low during RESULT -> all outputs reset values asynchronously; no ROUND_START after release.

Source files
------------

// File: rtl/game_round_ctrl_if.sv
// Board-side bundle for game_round_ctrl: key/verdict inputs and mode/score/status outputs.
interface game_round_ctrl_if #(
  parameter int NUM_KEYS = 7,
  parameter int HP_W     = 2,
  parameter int DIGITS   = 3
);
  logic [NUM_KEYS-1:0] KEY;
  logic [1:0]          JUDG;
  logic                JUDG_VLD;
  logic                WRONG;
  logic [2:0]          MODE;
  logic [HP_W-1:0]     HP_OUT;
  logic [4*DIGITS-1:0] COUNT_OUT;
  logic [NUM_KEYS-1:0] KEY_EDGE;
  logic                ROUND_START;
  logic                LEDR;

  modport master (
    output KEY, JUDG, JUDG_VLD, WRONG,
    input  MODE, HP_OUT, COUNT_OUT, KEY_EDGE, ROUND_START, LEDR
  );

  modport slave (
    input  KEY, JUDG, JUDG_VLD, WRONG,
    output MODE, HP_OUT, COUNT_OUT, KEY_EDGE, ROUND_START, LEDR
  );
endinterface

// File: rtl/game_round_ctrl.sv
// Game-flow controller: synchronised key edges, IDLE/READY/INPUT/RESULT/OVER mode FSM,
// HP (lives) counter and saturating BCD score.
module game_round_ctrl #(
  parameter int NUM_KEYS      = 7,
  parameter int HP_W          = 2,
  parameter int HP_INIT       = 3,
  parameter int DIGITS        = 3,
  parameter int RESULT_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RST,
  game_round_ctrl_if.slave  bus
);
  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    INPUT  = 3'd2,
    RESULT = 3'd3,
    OVER   = 3'd4
  } mode_e;

  // Score +1 with decimal ripple carry; an all-nines score is held rather than wrapped.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    logic          all9;
    r     = v;
    carry = 1'b1;
    all9  = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] != 4'd9) all9 = 1'b0;
      else                     all9 = all9;
    end
    if (!all9) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (carry && (v[4*k +: 4] == 4'd9)) begin
          r[4*k +: 4] = 4'd0;
        end else if (carry) begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          carry       = 1'b0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4];
        end
      end
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [NUM_KEYS-1:0] sync1_q, sync2_q, prev_q, kedge_q;
  mode_e               state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HP_W-1:0]     hp_q, hp_d;
  logic [SW-1:0]       score_q, score_d;
  logic                rs_q, led_q;
  logic                hp_dec, score_inc;

  // Two-flop synchroniser followed by a registered rising-edge detector.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      kedge_q <= '0;
    end else begin
      sync1_q <= bus.KEY;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      kedge_q <= sync2_q & ~prev_q;
    end
  end

  // Next mode, RESULT dwell count, HP and score.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hp_d      = hp_q;
    score_d   = score_q;
    // A verdict of 10 and a WRONG pulse in the same cycle merge into one decrement.
    hp_dec    = ((state_q == INPUT) && bus.JUDG_VLD && (bus.JUDG == 2'b10)) ||
                (bus.WRONG && ((state_q == INPUT) || (state_q == RESULT)));
    score_inc = (state_q == INPUT) && bus.JUDG_VLD && (bus.JUDG == 2'b01);
    if (hp_dec && (hp_q != '0)) hp_d = hp_q - 1'b1;
    else                        hp_d = hp_q;
    if (score_inc) score_d = bcd_inc(score_q);
    else           score_d = score_q;
    case (state_q)
      IDLE: begin
        if (kedge_q[0]) state_d = READY;
        else            state_d = IDLE;
      end
      READY: begin
        if (kedge_q[1]) state_d = INPUT;
        else            state_d = READY;
      end
      INPUT: begin
        if (bus.JUDG_VLD) begin
          state_d = RESULT;
          cnt_d   = '0;
        end else begin
          state_d = INPUT;
        end
      end
      RESULT: begin
        // Exit decision sees this cycle's HP update, so a late WRONG can still end the game.
        if (cnt_q == CNT_W'(RESULT_CYCLES - 1)) state_d = (hp_d != '0) ? INPUT : OVER;
        else                                   cnt_d   = cnt_q + 1'b1;
      end
      OVER: begin
        if (kedge_q[0]) begin
          state_d = IDLE;
          hp_d    = HP_W'(HP_INIT);
          score_d = '0;
        end else begin
          state_d = OVER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Mode, counters and registered status pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hp_q    <= HP_W'(HP_INIT);
      score_q <= '0;
      rs_q    <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      score_q <= score_d;
      rs_q    <= (state_d == INPUT) && (state_q != INPUT);
      led_q   <= (state_d == OVER);
    end
  end

  assign bus.MODE        = state_q;
  assign bus.HP_OUT      = hp_q;
  assign bus.COUNT_OUT   = score_q;
  assign bus.KEY_EDGE    = kedge_q;
  assign bus.ROUND_START = rs_q;
  assign bus.LEDR        = led_q;
endmodule

// File: tb/tb_game_round_ctrl.sv
// Scenario bench for game_round_ctrl: a small score/HP model feeds a scoreboard queue
// that is popped when the DUT reports the result of each round.
module tb_game_round_ctrl;
  localparam int NUM_KEYS = 7, HP_W = 2, HP_INIT = 3, DIGITS = 3, RESULT_CYCLES = 16;

  typedef struct {
    logic [11:0] score;
    logic [1:0]  hp;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   exp_score = 0;
  int   exp_hp = HP_INIT;
  exp_t sbq[$];
  logic [6:0] edge_q[$];
  logic [2:0] mode_q[$];
  logic       rs_q[$];

  always #5 CLK = ~CLK;

  game_round_ctrl_if #(.NUM_KEYS(NUM_KEYS), .HP_W(HP_W), .DIGITS(DIGITS)) bus ();

  game_round_ctrl #(
    .NUM_KEYS(NUM_KEYS), .HP_W(HP_W), .HP_INIT(HP_INIT),
    .DIGITS(DIGITS), .RESULT_CYCLES(RESULT_CYCLES)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  function automatic logic [11:0] to_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One INPUT->RESULT->exit round; optional WRONG pulse on the third RESULT cycle.
  task automatic do_round(input logic [1:0] j, input logic w, input logic res_wrong, input logic chk_len);
    exp_t e;
    exp_t got;
    int   n;
    checks++;
    if (bus.MODE !== 3'd2) begin
      failures++;
      $display("FAIL round_entry_mode got=%0d want=2", bus.MODE);
    end
    bus.JUDG = j; bus.JUDG_VLD = 1'b1; bus.WRONG = w;
    if (j == 2'b01 && exp_score < 999) exp_score++;
    if ((j == 2'b10 || w) && exp_hp > 0) exp_hp--;
    e.score = to_bcd(exp_score); e.hp = 2'(exp_hp);
    sbq.push_back(e);
    tick();
    bus.JUDG_VLD = 1'b0; bus.WRONG = 1'b0; bus.JUDG = 2'b00;
    got = sbq.pop_front();
    checks++;
    if (bus.MODE !== 3'd3) begin failures++; $display("FAIL round_result_mode got=%0d want=3", bus.MODE); end
    checks++;
    if (bus.COUNT_OUT !== got.score) begin failures++; $display("FAIL round_score got=%h want=%h", bus.COUNT_OUT, got.score); end
    checks++;
    if (bus.HP_OUT !== got.hp) begin failures++; $display("FAIL round_hp got=%0d want=%0d", bus.HP_OUT, got.hp); end
    n = 1;
    for (int i = 0; i < 100 && bus.MODE == 3'd3; i++) begin
      if (res_wrong && n == 3) begin
        bus.WRONG = 1'b1;
        if (exp_hp > 0) exp_hp--;
      end
      tick();
      bus.WRONG = 1'b0;
      if (bus.MODE == 3'd3) n++;
    end
    if (chk_len) begin
      checks++;
      if (n != RESULT_CYCLES) begin failures++; $display("FAIL result_len got=%0d want=%0d", n, RESULT_CYCLES); end
    end
    checks++;
    if (bus.MODE !== ((exp_hp > 0) ? 3'd2 : 3'd4)) begin
      failures++; $display("FAIL round_exit_mode got=%0d want=%0d", bus.MODE, (exp_hp > 0) ? 2 : 4);
    end
    checks++;
    if (bus.ROUND_START !== (exp_hp > 0)) begin
      failures++; $display("FAIL round_start got=%b want=%b", bus.ROUND_START, exp_hp > 0);
    end
    checks++;
    if (bus.HP_OUT !== 2'(exp_hp)) begin failures++; $display("FAIL exit_hp got=%0d want=%0d", bus.HP_OUT, exp_hp); end
  endtask

  task automatic test_reset();
    logic [6:0] ee;
    logic [2:0] em;
    bus.KEY = 7'b0000001; bus.JUDG = 2'b00; bus.JUDG_VLD = 1'b0; bus.WRONG = 1'b0;
    RST = 1'b0;
    idle_ticks(3);
    checks++; if (bus.MODE !== 3'd0) begin failures++; $display("FAIL reset_mode got=%0d want=0", bus.MODE); end
    checks++; if (bus.HP_OUT !== 2'd3) begin failures++; $display("FAIL reset_hp got=%0d want=3", bus.HP_OUT); end
    checks++; if (bus.COUNT_OUT !== 12'h000) begin failures++; $display("FAIL reset_score got=%h want=000", bus.COUNT_OUT); end
    checks++; if (bus.KEY_EDGE !== 7'd0) begin failures++; $display("FAIL reset_edge got=%b want=0", bus.KEY_EDGE); end
    checks++; if (bus.ROUND_START !== 1'b0) begin failures++; $display("FAIL reset_rs got=%b want=0", bus.ROUND_START); end
    checks++; if (bus.LEDR !== 1'b0) begin failures++; $display("FAIL reset_led got=%b want=0", bus.LEDR); end
    RST = 1'b1;
    edge_q = '{7'd0, 7'd0, 7'd1, 7'd0};
    mode_q = '{3'd0, 3'd0, 3'd0, 3'd1};
    for (int i = 0; i < 4; i++) begin
      tick();
      ee = edge_q.pop_front(); em = mode_q.pop_front();
      checks++; if (bus.KEY_EDGE !== ee) begin failures++; $display("FAIL start_edge c%0d got=%b want=%b", i, bus.KEY_EDGE, ee); end
      checks++; if (bus.MODE !== em) begin failures++; $display("FAIL start_mode c%0d got=%0d want=%0d", i, bus.MODE, em); end
    end
  endtask

  task automatic test_begin();
    logic [6:0] ee;
    logic [2:0] em;
    logic       er;
    bus.KEY = 7'b0000011;
    edge_q = '{7'd0, 7'd0, 7'b0000010, 7'd0, 7'd0};
    mode_q = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2};
    rs_q   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      tick();
      ee = edge_q.pop_front(); em = mode_q.pop_front(); er = rs_q.pop_front();
      checks++; if (bus.KEY_EDGE !== ee) begin failures++; $display("FAIL begin_edge c%0d got=%b want=%b", i, bus.KEY_EDGE, ee); end
      checks++; if (bus.MODE !== em) begin failures++; $display("FAIL begin_mode c%0d got=%0d want=%0d", i, bus.MODE, em); end
      checks++; if (bus.ROUND_START !== er) begin failures++; $display("FAIL begin_rs c%0d got=%b want=%b", i, bus.ROUND_START, er); end
    end
    checks++; if (bus.HP_OUT !== 2'd3) begin failures++; $display("FAIL begin_hp got=%0d want=3", bus.HP_OUT); end
    checks++; if (bus.COUNT_OUT !== 12'h000) begin failures++; $display("FAIL begin_score got=%h want=000", bus.COUNT_OUT); end
  endtask

  task automatic test_score();
    for (int r = 0; r < 12; r++) do_round(2'b01, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.COUNT_OUT !== 12'h012) begin failures++; $display("FAIL score12 got=%h want=012", bus.COUNT_OUT); end
  endtask

  task automatic test_saturate();
    for (int r = 0; r < 987; r++) do_round(2'b01, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.COUNT_OUT !== 12'h999) begin failures++; $display("FAIL score999 got=%h want=999", bus.COUNT_OUT); end
    do_round(2'b01, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.COUNT_OUT !== 12'h999) begin failures++; $display("FAIL score_sat got=%h want=999", bus.COUNT_OUT); end
  endtask

  task automatic test_merge();
    do_round(2'b10, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.HP_OUT !== 2'd2) begin failures++; $display("FAIL merge_hp got=%0d want=2", bus.HP_OUT); end
  endtask

  task automatic test_over();
    do_round(2'b10, 1'b0, 1'b0, 1'b0);
    do_round(2'b10, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.LEDR !== 1'b1) begin failures++; $display("FAIL over_led got=%b want=1", bus.LEDR); end
    checks++; if (bus.MODE !== 3'd4) begin failures++; $display("FAIL over_mode got=%0d want=4", bus.MODE); end
    bus.KEY = 7'b0000010;
    idle_ticks(5);
    bus.KEY = 7'b0000011;
    for (int i = 0; i < 10 && bus.MODE == 3'd4; i++) tick();
    exp_hp = HP_INIT; exp_score = 0;
    checks++; if (bus.MODE !== 3'd0) begin failures++; $display("FAIL restart_mode got=%0d want=0", bus.MODE); end
    checks++; if (bus.HP_OUT !== 2'd3) begin failures++; $display("FAIL restart_hp got=%0d want=3", bus.HP_OUT); end
    checks++; if (bus.COUNT_OUT !== 12'h000) begin failures++; $display("FAIL restart_score got=%h want=000", bus.COUNT_OUT); end
    checks++; if (bus.LEDR !== 1'b0) begin failures++; $display("FAIL restart_led got=%b want=0", bus.LEDR); end
  endtask

  task automatic test_ignore();
    bus.JUDG = 2'b10; bus.JUDG_VLD = 1'b1; bus.WRONG = 1'b1;
    tick();
    bus.JUDG = 2'b01;
    tick();
    bus.JUDG_VLD = 1'b0; bus.WRONG = 1'b0; bus.JUDG = 2'b00;
    tick();
    checks++; if (bus.MODE !== 3'd0) begin failures++; $display("FAIL ignore_mode got=%0d want=0", bus.MODE); end
    checks++; if (bus.HP_OUT !== 2'd3) begin failures++; $display("FAIL ignore_hp got=%0d want=3", bus.HP_OUT); end
    checks++; if (bus.COUNT_OUT !== 12'h000) begin failures++; $display("FAIL ignore_score got=%h want=000", bus.COUNT_OUT); end
  endtask

  task automatic test_reset_mid();
    logic [6:0] ee;
    logic       rs_seen;
    bus.KEY = 7'b0000000;
    idle_ticks(5);
    bus.KEY = 7'b0000001;
    idle_ticks(6);
    bus.KEY = 7'b0000011;
    for (int i = 0; i < 10 && bus.MODE != 3'd2; i++) tick();
    checks++; if (bus.MODE !== 3'd2) begin failures++; $display("FAIL mid_input_mode got=%0d want=2", bus.MODE); end
    bus.JUDG = 2'b01; bus.JUDG_VLD = 1'b1;
    tick();
    bus.JUDG_VLD = 1'b0; bus.JUDG = 2'b00;
    idle_ticks(3);
    checks++; if (bus.MODE !== 3'd3) begin failures++; $display("FAIL mid_result_mode got=%0d want=3", bus.MODE); end
    RST = 1'b0;
    #1;
    checks++; if (bus.MODE !== 3'd0) begin failures++; $display("FAIL async_mode got=%0d want=0", bus.MODE); end
    checks++; if (bus.HP_OUT !== 2'd3) begin failures++; $display("FAIL async_hp got=%0d want=3", bus.HP_OUT); end
    checks++; if (bus.COUNT_OUT !== 12'h000) begin failures++; $display("FAIL async_score got=%h want=000", bus.COUNT_OUT); end
    checks++; if (bus.KEY_EDGE !== 7'd0) begin failures++; $display("FAIL async_edge got=%b want=0", bus.KEY_EDGE); end
    checks++; if (bus.LEDR !== 1'b0) begin failures++; $display("FAIL async_led got=%b want=0", bus.LEDR); end
    tick();
    RST = 1'b1;
    rs_seen = 1'b0;
    edge_q = '{7'd0, 7'd0, 7'b0000011, 7'd0};
    for (int i = 0; i < 4; i++) begin
      tick();
      rs_seen = rs_seen | bus.ROUND_START;
      ee = edge_q.pop_front();
      checks++; if (bus.KEY_EDGE !== ee) begin failures++; $display("FAIL multi_edge c%0d got=%b want=%b", i, bus.KEY_EDGE, ee); end
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      rs_seen = rs_seen | bus.ROUND_START;
    end
    checks++; if (rs_seen !== 1'b0) begin failures++; $display("FAIL post_reset_rs got=%b want=0", rs_seen); end
    checks++; if (bus.MODE !== 3'd1) begin failures++; $display("FAIL post_reset_mode got=%0d want=1", bus.MODE); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_begin();
    test_score();
    test_saturate();
    test_merge();
    test_over();
    test_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
